// File: rtl/day16_t_ff_pkg.sv
// Shared constants for the day16_t_ff toggle-register slice.
//   DEFAULT_WIDTH       : default number of independent toggle bits
//   DEFAULT_RESET_VALUE : default reset load value (all zeros)
package day16_t_ff_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

endpackage : day16_t_ff_pkg

// File: rtl/day16_t_ff_t_ff_cell.sv
// Single T flip-flop with synchronous active-high reset to a per-bit value.
// Ports:
//   clk     : clock, rising-edge
//   rst     : synchronous reset, active-high; wins over toggle
//   t       : toggle enable, sampled every edge
//   rst_val : value loaded into q while rst is high
//   q       : registered flop state
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic rst_val,
  output logic q
);

  // Reset has priority; otherwise invert when t is set, hold when clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else begin
      q <= q ^ t;
    end
  end

endmodule : t_ff_cell

// File: rtl/day16_t_ff.sv
// WIDTH independent T flip-flops sharing clk and a synchronous reset.
// Ports:
//   clk   : clock, rising-edge
//   rst   : synchronous reset, active-high; loads RESET_VALUE
//   in    : per-bit toggle enable
//   t_out : registered toggle state, one flop per bit
module day16_t_ff
  import day16_t_ff_pkg::*;
#(
  parameter int unsigned           WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] t_out
);

  // One isolated cell per bit: no carry or interaction between positions.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .t       (in[i]),
      .rst_val (RESET_VALUE[i]),
      .q       (t_out[i])
    );
  end

endmodule : day16_t_ff

// File: tb/tb_day16_t_ff.sv
// Self-checking bench for day16_t_ff: default instance plus a RESET_VALUE=1100
// instance, both driven by the same stimulus.
module tb_day16_t_ff;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_v;
  logic [W-1:0] t_out_a;
  logic [W-1:0] t_out_b;

  int checks;
  int errors;

  day16_t_ff dut_a (
    .clk   (clk),
    .rst   (rst),
    .in    (in_v),
    .t_out (t_out_a)
  );

  day16_t_ff #(
    .WIDTH       (W),
    .RESET_VALUE (4'b1100)
  ) dut_b (
    .clk   (clk),
    .rst   (rst),
    .in    (in_v),
    .t_out (t_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each bit is its reset value flipped once per toggle request
  // counted since the last reset, i.e. reset value XOR parity of the count.
  int  toggle_cnt [W];
  bit  model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      for (int i = 0; i < W; i++) toggle_cnt[i] = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      for (int i = 0; i < W; i++) toggle_cnt[i] = toggle_cnt[i] + int'(in_v[i]);
    end
  end

  function automatic logic [W-1:0] model_q(input logic [W-1:0] rv);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = rv[i] ^ ((toggle_cnt[i] % 2) == 1);
    return r;
  endfunction

  // Cycle-by-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (t_out_a !== model_q(4'b0000)) begin
        errors++;
        $display("FAIL model_a t=%0t got=%b exp=%b", $time, t_out_a, model_q(4'b0000));
      end
      checks++;
      if (t_out_b !== model_q(4'b1100)) begin
        errors++;
        $display("FAIL model_b t=%0t got=%b exp=%b", $time, t_out_b, model_q(4'b1100));
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, land 1ns after it.
  task automatic cyc(input logic r, input logic [W-1:0] v);
    rst  = r;
    in_v = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b0;
    in_v = '0;
    @(negedge clk);

    // Reset held two edges with toggles requested.
    cyc(1'b1, 4'b1010); chk("rst_hold_e1", t_out_a, 4'b0000);
    chk("rst_val_b", t_out_b, 4'b1100);
    cyc(1'b1, 4'b1010); chk("rst_hold_e2", t_out_a, 4'b0000);

    // Repeated toggling from reset.
    cyc(1'b0, 4'b1010); chk("tog_1", t_out_a, 4'b1010);
    cyc(1'b0, 4'b1010); chk("tog_2", t_out_a, 4'b0000);
    cyc(1'b0, 4'b1010); chk("tog_3", t_out_a, 4'b1010);
    cyc(1'b0, 4'b1010); chk("tog_4", t_out_a, 4'b0000);

    // Reset mid-sequence with a new input pattern at the same edge.
    cyc(1'b0, 4'b1010); chk("pre_rst", t_out_a, 4'b1010);
    cyc(1'b1, 4'b1011); chk("rst_prio", t_out_a, 4'b0000);
    cyc(1'b0, 4'b1011); chk("post_rst_1", t_out_a, 4'b1011);
    cyc(1'b0, 4'b1011); chk("post_rst_2", t_out_a, 4'b0000);

    // Hold with no toggles.
    cyc(1'b0, 4'b0101); chk("set_0101", t_out_a, 4'b0101);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 4'b0000); chk("hold_0101", t_out_a, 4'b0101);
    end

    // Reset pulse entirely between edges must be ignored.
    rst = 1'b1; #2; rst = 1'b0; #1;
    chk("rst_glitch_mid", t_out_a, 4'b0101);
    cyc(1'b0, 4'b0000); chk("rst_glitch_edge", t_out_a, 4'b0101);

    // All bits toggling, with glitches on in between edges.
    cyc(1'b1, 4'b0000); chk("rst_again", t_out_a, 4'b0000);
    cyc(1'b0, 4'b1111); chk("all_1", t_out_a, 4'b1111);
    in_v = 4'b0101; #2;
    in_v = 4'b1010; #2;
    chk("in_glitch_mid", t_out_a, 4'b1111);
    cyc(1'b0, 4'b1111); chk("all_2", t_out_a, 4'b0000);

    // Non-zero reset value instance.
    cyc(1'b1, 4'b0000); chk("rv_b_rst", t_out_b, 4'b1100);
    cyc(1'b0, 4'b0001); chk("rv_b_tog", t_out_b, 4'b1101);
    chk("rv_a_tog", t_out_a, 4'b0001);

    // Randomized traffic with occasional resets, checked by the model.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 15) == 0), W'($urandom));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_day16_t_ff
